// File: rtl/context_scheduler_if.sv
// Handshake/status bundle between a core's context scheduler and its fetcher, LSU and thread units.
// master = environment driving the scheduler, slave = the scheduler itself.
interface context_scheduler_if #(
  parameter int PC_BITS = 8
);
  logic               start;
  logic [1:0]         ctx_valid;
  logic [7:0]         block_id_0;
  logic [7:0]         block_id_1;
  logic               fetch_done;
  logic               mem_pending;
  logic               decoded_ret;
  logic [PC_BITS-1:0] next_pc;
  logic [2:0]         core_state;
  logic               active_context;
  logic [7:0]         block_id;
  logic [PC_BITS-1:0] current_pc;
  logic [1:0]         ctx_done;
  logic               done;

  modport master (
    output start, ctx_valid, block_id_0, block_id_1, fetch_done, mem_pending,
           decoded_ret, next_pc,
    input  core_state, active_context, block_id, current_pc, ctx_done, done
  );

  modport slave (
    input  start, ctx_valid, block_id_0, block_id_1, fetch_done, mem_pending,
           decoded_ret, next_pc,
    output core_state, active_context, block_id, current_pc, ctx_done, done
  );
endinterface

// File: rtl/context_scheduler.sv
// Two-context per-core sequencer: runs the instruction state machine, keeps a saved PC per context
// and swaps contexts at instruction boundaries. Define SCHED_CTX_SWITCH_EN for memory-bound swaps.
module context_scheduler #(
  parameter int PC_BITS          = 8,
  parameter int WAIT_CNT_BITS    = 4,
  parameter int SWITCH_THRESHOLD = 4
) (
  input logic                clk,
  input logic                reset,
  context_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } state_t;

  state_t                   state_q, state_d;
  logic                     active_q, active_d;
  logic [1:0][PC_BITS-1:0]  pc_q, pc_d;
  logic [1:0]               ctx_done_q, ctx_done_d;
  logic                     done_q, done_d;
  logic                     other;
  logic                     other_runnable;
  logic                     mem_bound;

  assign other          = ~active_q;
  assign other_runnable = ~ctx_done_q[other];

`ifdef SCHED_CTX_SWITCH_EN
  localparam logic [WAIT_CNT_BITS-1:0] CNT_MAX = '1;

  logic [WAIT_CNT_BITS-1:0] wait_cnt_q, wait_cnt_d;

  // Counts memory-stalled WAIT cycles of the current instruction; saturates rather than wrapping.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == REQUEST)
      wait_cnt_d = '0;
    else if (state_q == WAIT && bus.mem_pending && wait_cnt_q != CNT_MAX)
      wait_cnt_d = wait_cnt_q + WAIT_CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  assign mem_bound = (wait_cnt_q >= WAIT_CNT_BITS'(SWITCH_THRESHOLD));
`else
  logic unused_cfg;
  assign unused_cfg = (WAIT_CNT_BITS > 0) && (SWITCH_THRESHOLD > 0);
  assign mem_bound  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pc_d       = pc_q;
    ctx_done_d = ctx_done_q;
    done_d     = done_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ctx_done_d = ~bus.ctx_valid;
          if (bus.ctx_valid == 2'b00) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            active_d = ~bus.ctx_valid[0];
            state_d  = FETCH;
          end
        end
      end
      FETCH:   if (bus.fetch_done) state_d = DECODE;
      DECODE:  state_d = REQUEST;
      REQUEST: state_d = WAIT;
      WAIT:    if (!bus.mem_pending) state_d = EXECUTE;
      EXECUTE: state_d = UPDATE;
      // Only edge where active_context may change, so an instruction never straddles two contexts.
      UPDATE: begin
        pc_d[active_q] = bus.next_pc;
        state_d        = FETCH;
        if (bus.decoded_ret) begin
          ctx_done_d[active_q] = 1'b1;
          if (other_runnable) begin
            active_d = other;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (mem_bound && other_runnable) begin
          active_d = other;
        end
      end
      DONE:    done_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      active_q   <= 1'b0;
      pc_q       <= '0;
      ctx_done_q <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pc_q       <= pc_d;
      ctx_done_q <= ctx_done_d;
      done_q     <= done_d;
    end
  end

  assign bus.core_state     = state_q;
  assign bus.active_context = active_q;
  assign bus.block_id       = active_q ? bus.block_id_1 : bus.block_id_0;
  assign bus.current_pc     = pc_q[active_q];
  assign bus.ctx_done       = ctx_done_q;
  assign bus.done           = done_q;

endmodule
